snn_setup_loader: RTL and testbench

- Host-side driver for the spiking-network core's setup/execute pin interface.
- Accepts commands plus a byte stream, then emits the data byte, `execute` and `setup_control` pattern the core shifts into its weight, batchnorm and input registers.
- Runs the network for a programmed number of cycles and accumulates per-output spike counts, with an argmax winner.
- Sits between a host FIFO/UART front end and the core's `ui_in`/`uio_in` pins; its `spikes` input is driven from the core's `uo_out`.

---
 rtl/snn_setup_loader.sv | 166 ++++++++++++++++
 tb/tb_snn_setup_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_setup_loader.sv
// Host-side loader for the spiking core setup/execute pins.
// Streams weight/batchnorm/input bytes, runs the net, counts spikes.
module snn_setup_loader #(
  parameter int WEIGHT_BYTES = 80,
  parameter int BN_BYTES     = 40,
  parameter int INPUT_BYTES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [7:0]            cmd_arg,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            snn_data,
  output logic                  snn_execute,
  output logic                  snn_setup_sync,
  output logic [2:0]            snn_setup_control,
  input  logic [7:0]            spikes,
  output logic [8*CNT_BITS-1:0] spike_counts,
  output logic [2:0]            winner,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [2:0] C_W    = 3'b001;
  localparam logic [2:0] C_BN   = 3'b110;
  localparam logic [2:0] C_IN   = 3'b000;
  localparam logic [2:0] C_IDLE = 3'b010;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [1:0]          state;
  logic [2:0]          code;
  logic [7:0]          target;
  logic [7:0]          nbytes;
  logic [7:0]          run_left;
  logic [DW-1:0]       drain_cnt;
  logic [CNT_BITS-1:0] cnt [8];
  logic                run_fire;

  assign cmd_ready = (state == S_IDLE);
  assign s_ready   = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign run_fire  = cmd_valid && cmd_ready && (cmd_op == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      code              <= C_IDLE;
      target            <= '0;
      nbytes            <= '0;
      run_left          <= '0;
      drain_cnt         <= '0;
      snn_data          <= '0;
      snn_execute       <= 1'b0;
      snn_setup_sync    <= 1'b0;
      snn_setup_control <= C_IDLE;
      done              <= 1'b0;
    end else begin
      done              <= 1'b0;
      snn_data          <= '0;
      snn_setup_sync    <= 1'b0;
      snn_setup_control <= C_IDLE;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            nbytes <= '0;
            unique case (cmd_op)
              2'b00: begin
                code   <= C_W;
                target <= 8'(WEIGHT_BYTES);
                state  <= S_LOAD;
              end
              2'b01: begin
                code   <= C_BN;
                target <= 8'(BN_BYTES);
                state  <= S_LOAD;
              end
              2'b10: begin
                code   <= C_IN;
                target <= 8'(INPUT_BYTES);
                state  <= S_LOAD;
              end
              2'b11: begin
                run_left    <= cmd_arg;
                drain_cnt   <= '0;
                snn_execute <= (cmd_arg != 8'd0);
                state <= (cmd_arg == 8'd0) ? S_DRAIN : S_RUN;
              end
            endcase
          end
        end
        S_LOAD: begin
          // byte is presented the cycle after it is accepted
          if (s_valid) begin
            snn_data          <= s_data;
            snn_setup_control <= code;
            snn_setup_sync    <= 1'b1;
            nbytes            <= nbytes + 8'd1;
            if (nbytes == target - 8'd1) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_left == 8'd1) begin
            snn_execute <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            run_left <= run_left - 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || run_fire) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (state == S_RUN || state == S_DRAIN) begin
      for (int i = 0; i < 8; i++) begin
        if (spikes[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign spike_counts[g*CNT_BITS +: CNT_BITS] = cnt[g];
  end

  // strict compare keeps the lowest index on ties
  always_comb begin
    logic [CNT_BITS-1:0] best;
    best   = cnt[0];
    winner = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (cnt[i] > best) begin
        best   = cnt[i];
        winner = 3'(i);
      end
    end
  end

endmodule

// File: tb/tb_snn_setup_loader.sv
// Bench for snn_setup_loader: table runs, directed loads,
// random commands against a spike-count / byte-order model.
module tb_snn_setup_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_arg = 8'd0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  snn_data;
  logic        snn_execute;
  logic        snn_setup_sync;
  logic [2:0]  snn_setup_control;
  logic [7:0]  spikes = 8'd0;
  logic [63:0] spike_counts;
  logic [2:0]  winner;
  logic        busy;
  logic        done;

  snn_setup_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .snn_data(snn_data), .snn_execute(snn_execute),
    .snn_setup_sync(snn_setup_sync),
    .snn_setup_control(snn_setup_control),
    .spikes(spikes), .spike_counts(spike_counts),
    .winner(winner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] pat;
    logic [7:0] cnt;
    logic [2:0] win;
  } run_vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [10:0] byte_q[$];
  int exec_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int first_exec_cyc = 0;
  int last_done_cyc = 0;
  int last_sync_cyc = 0;
  logic prev_exec = 1'b0;

  logic [10:0] exp_q[$];
  logic [7:0]  tx[$];
  int lb0, ld0, lv0, lacc;
  int mdl[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (snn_setup_sync) begin
        byte_q.push_back({snn_setup_control, snn_data});
        last_sync_cyc = cyc;
      end
      if (snn_execute) begin
        if (!prev_exec) first_exec_cyc = cyc;
        exec_cnt++;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if ((!snn_setup_sync && snn_setup_control != 3'b010) ||
          (snn_setup_sync && snn_execute) ||
          (snn_execute && snn_data != 8'd0))
        viol++;
      prev_exec = snn_execute;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_of(input int i);
    return spike_counts[i*8 +: 8];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cmd(input string nm);
    int tmo;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!cmd_ready && tmo < 50);
    if (!cmd_ready) begin
      failures++;
      $display("FAIL %s_cmd_timeout: got ready=0 expected 1", nm);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_send(input logic [1:0] op, input int nb,
                           input int gap_at, input int gap_len,
                           input int abort_at, input bit rnd_valid);
    logic [2:0] code;
    int sent, tmo, gap_left;
    bit acc;
    code = (op == 2'b00) ? 3'b001 :
           (op == 2'b01) ? 3'b110 : 3'b000;
    while (tx.size() < nb) tx.push_back(8'($urandom));
    exp_q.delete();
    lb0 = byte_q.size();
    ld0 = done_cnt;
    lv0 = viol;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = 8'($urandom);
    s_valid = 1'b1;
    s_data = 8'hEE;
    wait_cmd("load");
    sent = 0;
    tmo = 0;
    gap_left = gap_len;
    while (sent < nb && tmo < 2000) begin
      s_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent == gap_at && gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end
      s_data = tx[sent];
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      tmo++;
      if (acc) begin
        exp_q.push_back({code, tx[sent]});
        sent++;
        lacc = cyc;
        if (abort_at > 0 && sent == abort_at) break;
      end
    end
    s_valid = 1'b0;
    tx.delete();
    if (sent < nb && abort_at == 0) begin
      failures++;
      $display("FAIL load_byte_timeout: got %0d expected %0d",
               sent, nb);
    end
  endtask

  task automatic load_check(input string nm, input int nd,
                            input bit chk_last);
    int got;
    got = byte_q.size() - lb0;
    chk({nm, "_nbytes"}, got, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got; k++)
      chk($sformatf("%s_byte%0d", nm, k), byte_q[lb0+k], exp_q[k]);
    chk({nm, "_done_cnt"}, done_cnt - ld0, nd);
    if (chk_last) begin
      chk({nm, "_last_byte_cyc"}, last_sync_cyc, lacc);
      chk({nm, "_done_cyc"}, last_done_cyc, lacc);
    end
    chk({nm, "_protocol"}, viol - lv0, 0);
  endtask

  task automatic run_go(input logic [7:0] n, input logic [7:0] pat,
                        input bit rnd, output int acc);
    int e0, d0, v0, b0, w;
    logic [7:0] sp;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_arg = n;
    spikes = 8'($urandom);
    s_valid = 1'($urandom_range(0, 1));
    s_data = 8'($urandom);
    wait_cmd("run");
    acc = cyc;
    e0 = exec_cnt;
    d0 = done_cnt;
    v0 = viol;
    b0 = byte_q.size();
    chk("run_busy", busy, 1);
    for (int k = 0; k < int'(n) + 3; k++) begin
      sp = rnd ? 8'($urandom) : pat;
      spikes = sp;
      s_valid = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
      for (int i = 0; i < 8; i++)
        if (sp[i] && mdl[i] < 255) mdl[i]++;
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      spikes = 8'($urandom);
      @(posedge clk);
      #1;
    end
    spikes = 8'd0;
    s_valid = 1'b0;
    chk("run_exec_cycles", exec_cnt - e0, n);
    if (n != 8'd0) chk("run_exec_start", first_exec_cyc, acc);
    chk("run_done_cnt", done_cnt - d0, 1);
    chk("run_done_cyc", last_done_cyc, acc + int'(n) + 3);
    chk("run_no_bytes", byte_q.size() - b0, 0);
    chk("run_protocol", viol - v0, 0);
    w = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("run_cnt%0d", i), cnt_of(i), mdl[i]);
      if (mdl[i] > mdl[w]) w = i;
    end
    chk("run_winner", winner, w);
  endtask

  initial begin
    run_vec_t tbl[7];
    int acc;
    logic [1:0] op;

    tbl[0] = '{8'd4,   8'h81, 8'd7,   3'd0};
    tbl[1] = '{8'd255, 8'h08, 8'd255, 3'd3};
    tbl[2] = '{8'd0,   8'h22, 8'd3,   3'd1};
    tbl[3] = '{8'd10,  8'hF0, 8'd13,  3'd4};
    tbl[4] = '{8'd1,   8'h00, 8'd0,   3'd0};
    tbl[5] = '{8'd252, 8'h40, 8'd255, 3'd6};
    tbl[6] = '{8'd251, 8'h80, 8'd254, 3'd7};

    idle(3);
    reset = 1'b0;
    idle(10);
    chk("rst_ctrl", snn_setup_control, 3'b010);
    chk("rst_exec", snn_execute, 0);
    chk("rst_sync", snn_setup_sync, 0);
    chk("rst_data", snn_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_counts_lo", spike_counts[31:0], 0);
    chk("rst_counts_hi", spike_counts[63:32], 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_winner", winner, 0);

    tx.push_back(8'h5A);
    tx.push_back(8'hC3);
    load_send(2'b10, 2, -1, 0, 0, 1'b0);
    idle(3);
    load_check("inputs", 1, 1'b1);

    load_send(2'b00, 80, 10, 3, 0, 1'b0);
    idle(3);
    load_check("weights", 1, 1'b1);

    load_send(2'b01, 40, -1, 0, 0, 1'b0);
    run_go(8'd5, 8'h00, 1'b1, acc);
    chk("b2b_bubble", acc - 1, lacc);
    load_check("bn_chain", 2, 1'b0);

    foreach (tbl[t]) begin
      run_go(tbl[t].n, tbl[t].pat, 1'b0, acc);
      for (int i = 0; i < 8; i++)
        chk($sformatf("tbl%0d_cnt%0d", t, i), cnt_of(i),
            tbl[t].pat[i] ? tbl[t].cnt : 8'd0);
      chk($sformatf("tbl%0d_winner", t), winner, tbl[t].win);
      idle(2);
    end

    load_send(2'b00, 80, -1, 0, 30, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ctrl", snn_setup_control, 3'b010);
    chk("abort_sync", snn_setup_sync, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_counts", spike_counts[63:32] | spike_counts[31:0], 0);
    idle(4);
    chk("abort_no_done", done_cnt - ld0, 0);
    load_send(2'b01, 40, -1, 0, 0, 1'b1);
    idle(3);
    load_check("after_abort", 1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11) begin
        run_go(8'($urandom_range(0, 20)), 8'h00, 1'b1, acc);
      end else begin
        load_send(op, (op == 2'b00) ? 80 : (op == 2'b01) ? 40 : 2,
                  -1, 0, 0, 1'b1);
        idle(3);
        load_check($sformatf("rnd%0d", r), 1, 1'b1);
      end
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
